// File: rtl/ex_flag_stage.sv
// Execute-stage output register behind the ALU: flags, branch resolve, overflow trap.
// Optional build macro FLAG_FWD_EN: forward the incoming ALU flags into branch evaluation.
module ex_flag_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_alu,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_of,
    input  logic              alu_je,
    input  logic              alu_ja,
    input  logic [2:0]        br_cond,
    input  logic [DATA_W-1:0] br_target,
    input  logic              wr_en_in,
    input  logic [4:0]        wr_addr_in,
    input  logic              flush,
    input  logic              trap_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_wr_en,
    output logic [4:0]        out_wr_addr,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_addr,
    output logic [2:0]        flags_q,
    output logic              of_trap
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(2);

    state_t            r_state;
    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_wr_en;
    logic [4:0]        r_wr_addr;
    logic              r_br_taken;
    logic [DATA_W-1:0] r_br_addr;
    logic [2:0]        r_flags;
    logic              r_trap;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_flag_op;
    logic              w_of_hit;
    logic [2:0]        w_new_flags;
    logic [2:0]        w_br_flags;
    logic              w_cond;
    logic              w_take;

    assign w_in_ready  = !r_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready && !flush;
    assign w_flag_op   = (ctrl_alu == OP_ADD) || (ctrl_alu == OP_SUB);
    assign w_of_hit    = w_flag_op && alu_of;
    assign w_new_flags = {alu_of, alu_ja, alu_je};

`ifdef FLAG_FWD_EN
    // Branch sees the flags produced by the same instruction when it sets them
    assign w_br_flags = w_flag_op ? w_new_flags : r_flags;
`else
    // Branch sees the flag register as it stood before this instruction
    assign w_br_flags = r_flags;
`endif

    // Decode the branch condition against the selected {OF, A, E} set
    always_comb begin
        w_cond = 1'b0;
        case (br_cond)
            3'b001:  w_cond = 1'b1;
            3'b010:  w_cond = w_br_flags[0];
            3'b011:  w_cond = !w_br_flags[0];
            3'b100:  w_cond = w_br_flags[1];
            3'b101:  w_cond = !w_br_flags[1];
            3'b110:  w_cond = w_br_flags[2];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_take = w_accept && w_cond;

    // Occupancy FSM; flush kills the held entry and blocks any accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state <= S_FULL;
                        r_valid <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (flush) begin
                        r_state <= S_EMPTY;
                        r_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_state <= S_FULL;
                        r_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_state <= S_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Payload capture; an overflowing add/sub never writes back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
        end else if (w_accept) begin
            r_result  <= alu_result;
            r_wr_en   <= wr_en_in && !w_of_hit;
            r_wr_addr <= wr_addr_in;
        end
    end

    // Branch pulse: one cycle per accepted taken instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_taken <= 1'b0;
            r_br_addr  <= '0;
        end else begin
            r_br_taken <= w_take;
            if (w_take) begin
                r_br_addr <= br_target;
            end
        end
    end

    // Flag register follows accepted add/sub only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else if (w_accept && w_flag_op) begin
            r_flags <= w_new_flags;
        end
    end

    // Sticky overflow trap; a new overflow beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trap <= 1'b0;
        end else if (w_accept && w_of_hit) begin
            r_trap <= 1'b1;
        end else if (trap_clr) begin
            r_trap <= 1'b0;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_valid;
    assign out_result  = r_result;
    assign out_wr_en   = r_wr_en;
    assign out_wr_addr = r_wr_addr;
    assign br_taken    = r_br_taken;
    assign br_addr     = r_br_addr;
    assign flags_q     = r_flags;
    assign of_trap     = r_trap;

endmodule
